matvec_solve: RTL and testbench

Fixed-point matrix-vector multiplier that sits directly downstream of the `matinvN` inverter. It takes the flattened inverse `inv` and the inverter's singular flag, plus a right-hand-side vector `b`, and computes `x = inv · b`. This completes the `A·x = b` solve for the navigation filter. The datapath is a single time-multiplexed signed MAC over an N×N matrix, so a result takes N² cycles.

---
 rtl/nav_fixed_pkg.sv | 46 ++++
 rtl/matvec_solve_if.sv | 27 ++
 rtl/fixed_mac.sv | 50 +++++
 rtl/matvec_solve.sv | 137 +++++++++++++
 tb/tb_matvec_solve.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/nav_fixed_pkg.sv
// rtl/nav_fixed_pkg.sv - shared fixed-point helpers and state encoding for the nav solver blocks
// Contents: FIX_MAX_W working width, state_t FSM encoding, clog2, fixed_shift, fixed_sat.
package nav_fixed_pkg;

  // Wide enough for any accumulator we build (2*W + clog2(N) + 1) at W up to ~60.
  localparam int FIX_MAX_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) r = k + 1;
    end
    return r;
  endfunction

  // Arithmetic right shift: floor division by 2^bin_pos, no rounding.
  function automatic logic signed [FIX_MAX_W-1:0] fixed_shift(
    input logic signed [FIX_MAX_W-1:0] value,
    input int                          bin_pos
  );
    return value >>> bin_pos;
  endfunction

  // Clamp to the signed range of a width-bit word.
  function automatic logic signed [FIX_MAX_W-1:0] fixed_sat(
    input logic signed [FIX_MAX_W-1:0] value,
    input int                          width
  );
    logic signed [FIX_MAX_W-1:0] hi;
    logic signed [FIX_MAX_W-1:0] lo;
    hi = (FIX_MAX_W'(1) <<< (width - 1)) - FIX_MAX_W'(1);
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/matvec_solve_if.sv
// rtl/matvec_solve_if.sv - request/response bundle between a solve client and matvec_solve
// Signals: start/ready handshake, complete, matrix and vec operands, singular_in,
// result, overflow, singular_out. master = client side, slave = matvec_solve side.
interface matvec_solve_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 3
);
  logic                                            start;
  logic                                            ready;
  logic                                            complete;
  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix;
  logic [MATRIX_SIZE*DATA_WIDTH-1:0]               vec;
  logic                                            singular_in;
  logic [MATRIX_SIZE*DATA_WIDTH-1:0]               result;
  logic                                            overflow;
  logic                                            singular_out;

  modport master (
    output start, matrix, vec, singular_in,
    input  ready, complete, result, overflow, singular_out
  );

  modport slave (
    input  start, matrix, vec, singular_in,
    output ready, complete, result, overflow, singular_out
  );
endinterface

// File: rtl/fixed_mac.sv
// rtl/fixed_mac.sv - signed multiply-accumulate with clear and row-end shift/saturate
// Ports: clk, rst (async active-low), clr (zero accumulator), en (accumulate a*b),
// row_end (this term closes a row; accumulator restarts at zero), a, b (signed operands),
// row_value (shifted, saturated acc+a*b), row_clip (row_value was clipped).
module fixed_mac
  import nav_fixed_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         row_end,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic        [DATA_WIDTH-1:0] row_value,
  output logic                         row_clip
);
  localparam int PW = 2 * DATA_WIDTH;
  // N products of PW bits each cannot wrap this accumulator.
  localparam int AW = PW + clog2(MATRIX_SIZE) + 1;

  logic signed [PW-1:0]        prod;
  logic signed [AW-1:0]        acc;
  logic signed [AW-1:0]        acc_next;
  logic signed [FIX_MAX_W-1:0] shifted;
  logic signed [FIX_MAX_W-1:0] clamped;

  always_comb begin
    prod     = PW'(a) * PW'(b);
    acc_next = acc + {{(AW-PW){prod[PW-1]}}, prod};
    shifted  = fixed_shift({{(FIX_MAX_W-AW){acc_next[AW-1]}}, acc_next}, BIN_POS);
    clamped  = fixed_sat(shifted, DATA_WIDTH);
    row_value = clamped[DATA_WIDTH-1:0];
    row_clip  = (clamped != shifted);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= row_end ? '0 : acc_next;
    end
  end
endmodule

// File: rtl/matvec_solve.sv
// rtl/matvec_solve.sv - x = inv * b via one time-multiplexed fixed-point MAC (N*N cycles)
// Ports: clk, rst (async active-low), bus (matvec_solve_if.slave): start/ready accept a solve,
// matrix/vec/singular_in are captured on acceptance, complete qualifies result/overflow/singular_out.
module matvec_solve
  import nav_fixed_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 3
) (
  input logic           clk,
  input logic           rst,
  matvec_solve_if.slave bus
);
  localparam int N   = MATRIX_SIZE;
  localparam int W   = DATA_WIDTH;
  localparam int IW  = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int MIW = clog2(N*N*W);
  localparam int VIW = clog2(N*W);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  state_t              state;
  state_t              state_next;
  logic [IW-1:0]       i;
  logic [IW-1:0]       j;
  logic [N*N*W-1:0]    m_q;
  logic [N*W-1:0]      v_q;
  logic [N*W-1:0]      result_q;
  logic                overflow_q;
  logic                singular_q;
  // Holds complete low for one cycle after a singular capture so it rises after edge k+1.
  logic                settle_q;

  logic                accept;
  logic                mac_active;
  logic                row_end;
  logic                last_term;
  logic [MIW-1:0]      m_base;
  logic [VIW-1:0]      v_base;
  logic [VIW-1:0]      r_base;
  logic signed [W-1:0] m_elem;
  logic signed [W-1:0] v_elem;
  logic [W-1:0]        row_value;
  logic                row_clip;

  always_comb begin
    mac_active = (state == ST_MAC);
    accept     = bus.start && !mac_active;
    row_end    = mac_active && (j == LAST);
    last_term  = row_end && (i == LAST);
    m_base     = MIW'((int'(i) * N + int'(j)) * W);
    v_base     = VIW'(int'(j) * W);
    r_base     = VIW'(int'(i) * W);
    m_elem     = m_q[m_base +: W];
    v_elem     = v_q[v_base +: W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.ready    = 1'b1;
    bus.complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = bus.singular_in ? ST_DONE : ST_MAC;
      end
      ST_MAC: begin
        bus.ready = 1'b0;
        if (last_term) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.complete = !settle_q;
        if (accept) state_next = bus.singular_in ? ST_DONE : ST_MAC;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i          <= '0;
      j          <= '0;
      m_q        <= '0;
      v_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      singular_q <= 1'b0;
      settle_q   <= 1'b0;
    end else begin
      settle_q <= 1'b0;
      if (accept) begin
        m_q        <= bus.matrix;
        v_q        <= bus.vec;
        singular_q <= bus.singular_in;
        settle_q   <= bus.singular_in;
        result_q   <= '0;
        overflow_q <= 1'b0;
        i          <= '0;
        j          <= '0;
      end else if (mac_active) begin
        if (row_end) begin
          result_q[r_base +: W] <= row_value;
          if (row_clip) overflow_q <= 1'b1;
          j <= '0;
          i <= last_term ? '0 : i + ONE;
        end else begin
          j <= j + ONE;
        end
      end
    end
  end

  assign bus.result       = result_q;
  assign bus.overflow     = overflow_q;
  assign bus.singular_out = singular_q;

  fixed_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BIN_POS     (BIN_POS),
    .MATRIX_SIZE (MATRIX_SIZE)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (mac_active),
    .row_end   (row_end),
    .a         (m_elem),
    .b         (v_elem),
    .row_value (row_value),
    .row_clip  (row_clip)
  );
endmodule

// File: tb/tb_matvec_solve.sv
// tb/tb_matvec_solve.sv - scoreboard bench for matvec_solve (W=16, BIN_POS=8, N=2)
module tb_matvec_solve;
  localparam int W = 16;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matvec_solve_if #(.DATA_WIDTH(W), .MATRIX_SIZE(N)) bus ();

  matvec_solve #(.DATA_WIDTH(W), .BIN_POS(8), .MATRIX_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string          name;
    logic [N*W-1:0] result;
    logic           overflow;
    logic           singular;
    int             latency;
    int             start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [N*N*W-1:0] mk_m(input logic [W-1:0] a00, a01, a10, a11);
    return {a11, a10, a01, a00};
  endfunction

  function automatic logic [N*W-1:0] mk_v(input logic [W-1:0] b0, b1);
    return {b1, b0};
  endfunction

  // Called at a negedge: drives a request that the next posedge samples.
  task automatic issue(input string name, input logic [N*N*W-1:0] m, input logic [N*W-1:0] v,
                       input logic sing, input logic [N*W-1:0] res, input logic ovf,
                       input int lat, input logic track);
    exp_t e;
    bus.matrix      = m;
    bus.vec         = v;
    bus.singular_in = sing;
    bus.start       = 1'b1;
    if (track) begin
      e.name      = name;
      e.result    = res;
      e.overflow  = ovf;
      e.singular  = sing;
      e.latency   = lat;
      e.start_cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (bus.complete !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.complete !== 1'b1) check({name, "_timeout"}, 64'(bus.complete), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
    check({tag, "_complete"}, 64'(bus.complete), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'd0);
    check({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
    check({tag, "_singular_out"}, 64'(bus.singular_out), 64'd0);
  endtask

  // Monitor: pops one expectation per rising edge of complete.
  logic prev_complete = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.complete === 1'b1 && prev_complete !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_complete", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, 64'(bus.result), 64'(e.result));
        check({e.name, "_overflow"}, 64'(bus.overflow), 64'(e.overflow));
        check({e.name, "_singular_out"}, 64'(bus.singular_out), 64'(e.singular));
        check({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'(e.latency));
      end
    end
    prev_complete = bus.complete;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [W-1:0] ONE_FX = 16'h0100;

  initial begin
    bus.start       = 1'b0;
    bus.matrix      = '0;
    bus.vec         = '0;
    bus.singular_in = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Identity: result equals vec, 4 MAC cycles.
    issue("identity", mk_m(ONE_FX, 0, 0, ONE_FX), mk_v(16'h0300, 16'hFE00), 1'b0,
          mk_v(16'h0300, 16'hFE00), 1'b0, 4, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("identity_ready_in_mac", 64'(bus.ready), 64'd0);
    wait_done("identity");
    @(negedge clk);

    // Fraction handling; an extra start with junk inputs mid-MAC must be ignored.
    issue("fraction", mk_m(16'h0200, 16'h0080, 16'h0000, 16'h0080), mk_v(16'h0100, 16'h0400),
          1'b0, mk_v(16'h0400, 16'h0200), 1'b0, 4, 1'b1);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.vec    = mk_v(16'h7FFF, 16'h7FFF);
    bus.matrix = '1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("fraction");
    @(negedge clk);

    // Positive saturation.
    issue("sat_pos", mk_m(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00), mk_v(16'h7F00, 16'h7F00),
          1'b0, mk_v(16'h7FFF, 16'h7FFF), 1'b1, 4, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("sat_pos");
    @(negedge clk);

    // Negative saturation.
    issue("sat_neg", mk_m(16'h8100, 16'h8100, 16'h8100, 16'h8100), mk_v(16'h7F00, 16'h7F00),
          1'b0, mk_v(16'h8000, 16'h8000), 1'b1, 4, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("sat_neg");
    @(negedge clk);

    // Singular: no MAC, complete one cycle later, ready stays high, overflow cleared.
    issue("singular", mk_m(16'h1234, 16'h5678, 16'h7ABC, 16'h0DEF), mk_v(16'h0300, 16'h0400),
          1'b1, '0, 1'b0, 1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("singular_ready_cycle1", 64'(bus.ready), 64'd1);
    check("singular_complete_cycle1", 64'(bus.complete), 64'd0);
    @(negedge clk);
    check("singular_ready_cycle2", 64'(bus.ready), 64'd1);
    wait_done("singular");
    @(negedge clk);

    // Start ignored mid-MAC, then asynchronous reset discards the partial solve.
    issue("aborted", mk_m(ONE_FX, 0, 0, ONE_FX), mk_v(16'h0300, 16'hFE00), 1'b0,
          '0, 1'b0, 0, 1'b0);
    @(negedge clk);
    bus.vec = mk_v(16'h1111, 16'h2222);
    check("abort_ready_in_mac", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    #1;
    check_reset_outputs("midmac_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_idle_complete", 64'(bus.complete), 64'd0);
    check("post_reset_idle_ready", 64'(bus.ready), 64'd1);

    issue("identity_after_reset", mk_m(ONE_FX, 0, 0, ONE_FX), mk_v(16'h0300, 16'hFE00), 1'b0,
          mk_v(16'h0300, 16'hFE00), 1'b0, 4, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("identity_after_reset");

    // Back-to-back: start in DONE at the same negedge complete is seen.
    issue("back_to_back", mk_m(ONE_FX, 0, 0, ONE_FX), mk_v(16'h0100, 16'h0100), 1'b0,
          mk_v(16'h0100, 16'h0100), 1'b0, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("back_to_back_low_%0d", k), 64'(bus.complete), 64'd0);
    end
    wait_done("back_to_back");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
